cpu_run_ctrl: RTL and testbench

Program-store and run controller for the 4-bit `cpu` core. It holds the 16 x 8 instruction store and answers the core's `addr` with `opecode`/`imm`. It sequences the core through load, run, halt and single-step, with one address breakpoint. It owns the core's reset, and sits between the board-level debug/load interface and the core.

---
 rtl/cpu_run_ctrl.sv | 69 ++++++
 tb/tb_cpu_run_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: program store and load/run/halt/step sequencer for the 4-bit cpu core
module cpu_run_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [3:0]       addr,
    output logic [3:0]       opecode,
    output logic [3:0]       imm,
    output logic             cpu_n_rst,
    input  logic             ld_valid,
    input  logic [3:0]       ld_addr,
    input  logic [7:0]       ld_data,
    output logic             ld_ready,
    input  logic             cmd_load,
    input  logic             cmd_halt,
    input  logic             cmd_step,
    input  logic             cmd_run,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] exec_count
);
    typedef enum logic [1:0] {LOAD = 2'd0, HALT = 2'd1, RUN = 2'd2, STEP = 2'd3} state_t;
    state_t     cur, nxt;
    logic [7:0] mem [16];
    logic       first_run, bp_block, issue, bp_set, bp_clr;
    assign state    = cur;
    assign ld_ready = cur == LOAD;
    assign bp_block = bp_en && addr == bp_addr && !first_run;
    assign issue    = (cur == RUN && !bp_block) || cur == STEP;
    assign {opecode, imm} = issue ? mem[addr] : {4'hF, addr};
    always_comb begin
        nxt    = cur;
        bp_set = 1'b0;
        bp_clr = 1'b0;
        case (cur)
            LOAD: nxt = cmd_halt ? HALT : cmd_step ? STEP : cmd_run ? RUN : LOAD;
            HALT: nxt = cmd_load ? LOAD : cmd_halt ? HALT : cmd_step ? STEP : cmd_run ? RUN : HALT;
            RUN:  nxt = cmd_load ? LOAD : (cmd_halt || bp_block) ? HALT : RUN;
            STEP: nxt = cmd_load ? LOAD : HALT;
        endcase
        bp_set = cur == RUN && !cmd_load && !cmd_halt && bp_block;
        // every transition that does not land in HALT is an accepted load/step/run
        bp_clr = nxt != cur && nxt != HALT;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur        <= LOAD;
            cpu_n_rst  <= 1'b0;
            first_run  <= 1'b0;
            bp_hit     <= 1'b0;
            exec_count <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else begin
            cur       <= nxt;
            cpu_n_rst <= nxt != LOAD;
            first_run <= nxt == RUN && cur != RUN;
            bp_hit    <= bp_set ? 1'b1 : bp_clr ? 1'b0 : bp_hit;
            if (nxt == LOAD && cur != LOAD)
                exec_count <= '0;
            else if (issue && !(&exec_count))
                exec_count <= exec_count + 1'b1;
            if (ld_valid && cur == LOAD)
                mem[ld_addr] <= ld_data;
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed checks of cpu_run_ctrl driving a minimal behavioural core
module tb_cpu_run_ctrl;
    logic        clk = 1'b0, n_rst = 1'b0;
    logic [3:0]  addr, opecode, imm, ld_addr = '0, bp_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        cpu_n_rst, ld_valid = 1'b0, ld_ready, bp_en = 1'b0, bp_hit;
    logic        cmd_load = 1'b0, cmd_halt = 1'b0, cmd_step = 1'b0, cmd_run = 1'b0;
    logic [1:0]  state;
    logic [15:0] exec_count;
    logic [3:0]  s_opecode, s_imm, s_exec_count;
    logic        s_cpu_n_rst, s_ld_ready, s_bp_hit;
    logic [1:0]  s_state;
    logic [3:0]  pc, b, led;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl u_dut (
        .clk(clk), .n_rst(n_rst), .addr(addr), .opecode(opecode), .imm(imm),
        .cpu_n_rst(cpu_n_rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .cmd_load(cmd_load), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
        .cmd_run(cmd_run), .bp_en(bp_en), .bp_addr(bp_addr), .state(state),
        .bp_hit(bp_hit), .exec_count(exec_count)
    );

    cpu_run_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .n_rst(n_rst), .addr(addr), .opecode(s_opecode), .imm(s_imm),
        .cpu_n_rst(s_cpu_n_rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(s_ld_ready), .cmd_load(cmd_load), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
        .cmd_run(cmd_run), .bp_en(bp_en), .bp_addr(bp_addr), .state(s_state),
        .bp_hit(s_bp_hit), .exec_count(s_exec_count)
    );

    // minimal core: 7=MOV B,imm  9=OUT B  F=JMP imm, anything else just advances
    always @(posedge clk or negedge cpu_n_rst) begin
        if (!cpu_n_rst) begin
            pc <= '0; b <= '0; led <= '0;
        end else begin
            pc <= opecode == 4'hF ? imm : pc + 4'd1;
            if (opecode == 4'h7) b <= imm;
            if (opecode == 4'h9) led <= b;
        end
    end
    assign addr = pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic l, input logic h, input logic s, input logic r);
        {cmd_load, cmd_halt, cmd_step, cmd_run} = {l, h, s, r};
        cyc();
        {cmd_load, cmd_halt, cmd_step, cmd_run} = 4'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(2);
        check("rst_state", state, 0);
        check("rst_cpu_n_rst", cpu_n_rst, 0);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_exec_count", exec_count, 0);
        check("rst_stall", {opecode, imm}, 8'hF0);
        n_rst = 1'b1;
        cyc();
        ld_valid = 1'b1;
        ld_addr = 4'd0; ld_data = 8'h7A; cyc();
        ld_addr = 4'd1; ld_data = 8'h90; cyc();
        ld_addr = 4'd2; ld_data = 8'hF2; cyc();
        ld_valid = 1'b0;
        pulse(0, 0, 0, 1);
        check("run_state", state, 2);
        check("run_cpu_n_rst", cpu_n_rst, 1);
        check("run_first_issue", {opecode, imm}, 8'h7A);
        check("run_count0", exec_count, 0);
        cyc(2);
        check("run_led", led, 10);
        check("run_count2", exec_count, 2);
        cyc();
        check("run_addr_hold", addr, 2);
        check("run_count3", exec_count, 3);

        pulse(1, 0, 0, 0);
        check("load_state", state, 0);
        check("load_count_clr", exec_count, 0);
        check("load_core_rst", {addr, led}, 8'h00);
        cmd_run = 1'b1; cyc();
        cmd_run = 1'b0; cmd_halt = 1'b1; cyc();
        cmd_halt = 1'b0;
        check("halt_state", state, 1);
        check("halt_addr", addr, 1);
        check("halt_stall", {opecode, imm}, 8'hF1);
        cyc(10);
        check("halt_hold_addr", addr, 1);
        check("halt_hold_led", led, 0);
        check("halt_hold_count", exec_count, 1);
        pulse(0, 0, 1, 0);
        check("step_state", state, 3);
        check("step_issue", {opecode, imm}, 8'h90);
        cyc();
        check("step_back_halt", state, 1);
        check("step_led", led, 10);
        check("step_addr", addr, 2);
        check("step_count", exec_count, 2);

        pulse(1, 0, 0, 0);
        bp_en = 1'b1; bp_addr = 4'd1;
        pulse(0, 0, 0, 1);
        cyc();
        check("bp_block_stall", {opecode, imm}, 8'hF1);
        cyc();
        check("bp_state", state, 1);
        check("bp_hit_set", bp_hit, 1);
        check("bp_addr", addr, 1);
        check("bp_count", exec_count, 1);
        pulse(0, 0, 0, 1);
        check("bp_resume_state", state, 2);
        check("bp_hit_clr", bp_hit, 0);
        check("bp_resume_issue", {opecode, imm}, 8'h90);
        cyc();
        check("bp_resume_addr", addr, 2);
        check("bp_resume_led", led, 10);
        bp_en = 1'b0;

        ld_valid = 1'b1; ld_addr = 4'd0; ld_data = 8'hFF;
        check("wr_ld_ready", ld_ready, 0);
        cyc(2);
        ld_valid = 1'b0;
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        check("wr_ignored", {opecode, imm}, 8'h7A);

        pulse(0, 1, 0, 0);
        check("prio_halt", state, 1);
        pulse(1, 0, 0, 1);
        check("prio_load_over_run", state, 0);
        pulse(0, 0, 1, 1);
        check("prio_step_over_run", state, 3);
        cyc();
        check("prio_step_to_halt", state, 1);

        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        cyc(20);
        check("count_20", exec_count, 20);
        check("sat_count", s_exec_count, 15);

        #2 n_rst = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_cpu_n_rst", cpu_n_rst, 0);
        check("arst_count", exec_count, 0);
        check("arst_stall", {opecode, imm}, 8'hF0);
        cyc();
        n_rst = 1'b1;
        pulse(0, 0, 0, 1);
        check("arst_store_clr", {opecode, imm}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
